mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter ADDR_LIMIT, default 64'd8192, exclusive upper bound of valid data addresses.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum cycles held in REQ without mem_ack.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to process the current instruction's memory phase.
REQ-006 in_code  input  4  Y86 icode of the instruction.
REQ-007 val_e  input  64  execute-stage result (address for icodes 4, 5, 8, 10).
REQ-008 val_a  input  64  register operand (write data for 4/10; address for 9/11).
REQ-009 val_p  input  64  next PC (write data for 8).
REQ-010 mem_req  output  1  data-memory request, held until mem_ack.
REQ-011 mem_we  output  1  1 = write, 0 = read; valid while mem_req high.
REQ-012 mem_addr  output  64  access address; valid while mem_req high.
REQ-013 mem_wdata  output  64  write data; valid while mem_req high with mem_we=1.
REQ-014 mem_ack  input  1  memory completion; sampled only in REQ.
REQ-015 mem_rdata  input  64  read data; valid in the mem_ack cycle.
REQ-016 mem_err  input  1  bus error; valid in the mem_ack cycle.
REQ-017 val_m  output  64  last successfully read data.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 dmem_error  output  1  error status of the last operation; valid from done until next start accepted.

Function
REQ-021 States SHALL be IDLE, REQ, DONE; busy=1 in REQ and DONE.
REQ-022 In IDLE, start=1 SHALL latch in_code, val_e, val_a, val_p and clear dmem_error; start SHALL be ignored in REQ and DONE.
REQ-023 Mapping SHALL be: 4 write M[val_e]=val_a; 5 read M[val_e]; 8 write M[val_e]=val_p; 9 read M[val_a]; 10 write M[val_e]=val_a; 11 read M[val_a].
REQ-024 Accepted start with any other icode SHALL go directly to DONE, no mem_req, val_m unchanged, dmem_error=0.
REQ-025 Accepted start with a memory icode SHALL go to REQ; mem_req, mem_we, mem_addr, mem_wdata registered, first driven the cycle after start.
REQ-026 mem_addr, mem_we, mem_wdata SHALL stay constant while mem_req=1; mem_req SHALL drop the cycle after mem_ack.
REQ-027 mem_ack=1, mem_err=0 on a read SHALL load val_m from mem_rdata; then DONE.
REQ-028 mem_ack=1, mem_err=1 SHALL set dmem_error, leave val_m unchanged; then DONE.
REQ-029 Wait counter SHALL clear on REQ entry and increment each REQ cycle without mem_ack; reaching TIMEOUT_CYCLES SHALL set dmem_error, drop mem_req, go to DONE.
REQ-030 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority (normal completion).
REQ-031 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-032 Latency: start at cycle T, mem_ack at T+k (k>=1) SHALL give done at T+k+1; non-memory icode SHALL give done at T+1.
REQ-033 mem_ack or mem_err outside REQ SHALL be ignored.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, val_m=0, done=0, busy=0, dmem_error=0, counter=0, including mid-REQ.
REQ-035 First start SHALL be accepted on the first rising edge with reset_n=1.

Configuration
REQ-036 With DMEM_BOUNDS_CHECK_EN defined, a memory access with address >= ADDR_LIMIT SHALL skip REQ, assert no mem_req, set dmem_error, and go to DONE (done at T+1).
REQ-037 Without DMEM_BOUNDS_CHECK_EN, all addresses SHALL be forwarded to memory unchecked; errors SHALL come only from mem_err or timeout.

Verification
REQ-038 start, in_code=4, val_e=0x100, val_a=0xDEAD; ack 3 cycles later -> mem_req=1, mem_we=1, addr 0x100, wdata 0xDEAD held; done 1 cycle after ack; dmem_error=0.
REQ-039 start, in_code=11, val_a=0x200; ack with mem_rdata=0x1234 -> mem_we=0, addr 0x200, val_m=0x1234 at done.
REQ-040 start, in_code=6 -> no mem_req, done at T+1, val_m unchanged.
REQ-041 start, in_code=5, ack never asserted -> mem_req held 16 cycles, then dropped, done=1, dmem_error=1.
REQ-042 With DMEM_BOUNDS_CHECK_EN: start, in_code=8, val_e=0x2000 -> no mem_req, done at T+1, dmem_error=1; without macro -> mem_req to 0x2000, wdata=val_p.
REQ-043 reset_n low during REQ -> mem_req=0, busy=0 immediately; mem_ack after reset release ignored; next start accepted normally.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory phase of a Y86 pipeline step.
// Turns one accepted start into at most one data-memory transaction, with a
// wait-cycle timeout. Optional macro DMEM_BOUNDS_CHECK_EN rejects addresses
// at or above ADDR_LIMIT without touching memory.
module mem_access #(
    parameter logic [63:0] ADDR_LIMIT     = 64'd8192,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  in_code,
    input  logic [63:0] val_e,
    input  logic [63:0] val_a,
    input  logic [63:0] val_p,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic [63:0] val_m,
    output logic        done,
    output logic        busy,
    output logic        dmem_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [63:0]     mem_addr_q, mem_addr_d;
    logic [63:0]     mem_wdata_q, mem_wdata_d;
    logic [63:0]     val_m_q, val_m_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            dmem_error_q, dmem_error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            dec_mem;
    logic            dec_we;
    logic [63:0]     dec_addr;
    logic [63:0]     dec_wdata;
    logic            dec_oob;

    // Decode icode into access direction, address and write data.
    always_comb begin
        dec_mem   = 1'b1;
        dec_we    = 1'b0;
        dec_addr  = 64'd0;
        dec_wdata = 64'd0;
        case (in_code)
            4'd4:  begin dec_we = 1'b1; dec_addr = val_e; dec_wdata = val_a; end
            4'd5:  begin dec_addr = val_e; end
            4'd8:  begin dec_we = 1'b1; dec_addr = val_e; dec_wdata = val_p; end
            4'd9:  begin dec_addr = val_a; end
            4'd10: begin dec_we = 1'b1; dec_addr = val_e; dec_wdata = val_a; end
            4'd11: begin dec_addr = val_a; end
            default: dec_mem = 1'b0;
        endcase
        dec_oob = BOUNDS_EN && (dec_addr >= ADDR_LIMIT);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        val_m_d      = val_m_q;
        done_d       = 1'b0;
        dmem_error_d = dmem_error_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dmem_error_d = 1'b0;
                    if (!dec_mem) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (dec_oob) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        dmem_error_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dec_we;
                        mem_addr_d  = dec_addr;
                        mem_wdata_d = dec_wdata;
                        cnt_d       = '0;
                    end
                end
            end
            ST_REQ: begin
                // Ack wins over a timeout landing on the same edge.
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    if (mem_err) begin
                        dmem_error_d = 1'b1;
                    end else if (!mem_we_q) begin
                        val_m_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    mem_req_d    = 1'b0;
                    dmem_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
            val_m_q      <= 64'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            dmem_error_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            val_m_q      <= val_m_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            dmem_error_q <= dmem_error_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign val_m      = val_m_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign dmem_error = dmem_error_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expectations queued at start, checked
// while mem_req is up and when done pulses.
module tb_mem_access;

    localparam logic [63:0] LIMIT = 64'd8192;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  in_code = 4'd0;
    logic [63:0] val_e = 64'd0;
    logic [63:0] val_a = 64'd0;
    logic [63:0] val_p = 64'd0;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic        mem_err = 1'b0;
    logic [63:0] val_m;
    logic        done;
    logic        busy;
    logic        dmem_error;

    mem_access dut (
        .clock(clock), .reset_n(reset_n), .start(start), .in_code(in_code),
        .val_e(val_e), .val_a(val_a), .val_p(val_p),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .val_m(val_m), .done(done), .busy(busy), .dmem_error(dmem_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          has_req;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] val_m;
        bit          err;
        int          lat;
        int          req_cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          req_cycles = 0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_vm = 64'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: check held request fields each cycle, retire on done.
    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_req) begin
                req_cycles++;
                if (sb.size() == 0 || !sb[0].has_req) begin
                    check_eq("unexpected_req", 64'd1, 64'd0);
                end else begin
                    check_eq("mem_we", 64'(mem_we), 64'(sb[0].we));
                    check_eq("mem_addr", mem_addr, sb[0].addr);
                    if (sb[0].we) check_eq("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check_eq("latency", 64'(cyc - start_cyc), 64'(x.lat));
                    check_eq("req_cycles", 64'(req_cycles), 64'(x.req_cycles));
                    check_eq("dmem_error", 64'(dmem_error), 64'(x.err));
                    check_eq("val_m", val_m, x.val_m);
                    check_eq("busy_at_done", 64'(busy), 64'd1);
                end
                req_cycles = 0;
            end
        end
    end

    // Drive one operation; ack_k = 0 means memory never answers.
    task automatic run_op(input logic [3:0] code, input logic [63:0] e, input logic [63:0] a,
                          input logic [63:0] p, input int ack_k, input logic [63:0] rdata,
                          input logic err);
        exp_t        x;
        bit          mop;
        bit          we;
        logic [63:0] ad;
        logic [63:0] wd;
        mop = 1'b1; we = 1'b0; ad = 64'd0; wd = 64'd0;
        case (code)
            4'd4:  begin we = 1'b1; ad = e; wd = a; end
            4'd5:  ad = e;
            4'd8:  begin we = 1'b1; ad = e; wd = p; end
            4'd9:  ad = a;
            4'd10: begin we = 1'b1; ad = e; wd = a; end
            4'd11: ad = a;
            default: mop = 1'b0;
        endcase
        x.has_req = 1'b0; x.we = we; x.addr = ad; x.wdata = wd;
        x.err = 1'b0; x.lat = 1; x.req_cycles = 0;
        if (mop) begin
            if (BOUNDS && ad >= LIMIT) begin
                x.err = 1'b1;
            end else begin
                x.has_req = 1'b1;
                if (ack_k == 0) begin
                    x.lat = 17; x.req_cycles = 16; x.err = 1'b1;
                end else begin
                    x.lat = ack_k + 1; x.req_cycles = ack_k; x.err = err;
                    if (!err && !we) exp_vm = rdata;
                end
            end
        end
        x.val_m = exp_vm;
        sb.push_back(x);

        @(negedge clock);
        start = 1'b1; in_code = code; val_e = e; val_a = a; val_p = p;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0; in_code = 4'd0; val_e = 64'd0; val_a = 64'd0; val_p = 64'd0;
        if (x.has_req && ack_k > 0) begin
            repeat (ack_k - 1) @(negedge clock);
            mem_ack = 1'b1; mem_rdata = rdata; mem_err = err;
            @(negedge clock);
            mem_ack = 1'b0; mem_rdata = 64'd0; mem_err = 1'b0;
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check_eq("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dmem_error", 64'(dmem_error), 64'd0);
        check_eq("rst_val_m", val_m, 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        mon_en = 1'b1;

        run_op(4'd4, 64'h100, 64'hDEAD, 64'h0, 3, 64'h0, 1'b0);
        run_op(4'd11, 64'h0, 64'h200, 64'h0, 1, 64'h1234, 1'b0);
        run_op(4'd6, 64'h100, 64'h200, 64'h300, 1, 64'h0, 1'b0);
        run_op(4'd5, 64'h40, 64'h0, 64'h0, 0, 64'h0, 1'b0);
        run_op(4'd8, 64'h2000, 64'h0, 64'h55, 2, 64'h0, 1'b0);
        run_op(4'd9, 64'h0, 64'h300, 64'h0, 2, 64'hBAD, 1'b1);
        run_op(4'd5, 64'h18, 64'h0, 64'h0, 16, 64'hCAFE, 1'b0);
        run_op(4'd10, 64'h1FF8, 64'h77, 64'h0, 1, 64'h0, 1'b0);
        run_op(4'd9, 64'h0, 64'h1FF0, 64'h0, 4, 64'h5A5A, 1'b0);
        run_op(4'd0, 64'h0, 64'h0, 64'h0, 1, 64'h0, 1'b0);

        // Reset in the middle of a request, then a stray ack.
        mon_en = 1'b0;
        @(negedge clock);
        start = 1'b1; in_code = 4'd5; val_e = 64'h80;
        @(negedge clock);
        start = 1'b0;
        check_eq("pre_rst_req", 64'(mem_req), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 64'(mem_req), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_val_m", val_m, 64'd0);
        exp_vm = 64'd0;
        @(negedge clock);
        reset_n = 1'b1;
        mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 64'hFFFF;
        @(negedge clock);
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'd0;
        check_eq("stray_ack_req", 64'(mem_req), 64'd0);
        check_eq("stray_ack_done", 64'(done), 64'd0);
        check_eq("stray_ack_err", 64'(dmem_error), 64'd0);
        req_cycles = 0;
        mon_en = 1'b1;

        run_op(4'd11, 64'h0, 64'h208, 64'h0, 2, 64'h4321, 1'b0);
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
